// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick scheduler slice.
package tick_sched_pkg;

    localparam int unsigned TS_W_DEF  = 16;
    localparam int unsigned TS_CW_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/tick_sched_if.sv
// Config handshake, sequence control and tick status bundle for tick_sched_ctrl.
interface tick_sched_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 8
) ();

    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_dvsr;
    logic [CW-1:0] cfg_cnt;
    logic          start;
    logic          stop;
    logic          tick;
    logic [W-1:0]  q;
    logic [CW-1:0] tick_cnt;
    logic          busy;
    logic          done;

    modport master (
        output cfg_valid, cfg_dvsr, cfg_cnt, start, stop,
        input  cfg_ready, tick, q, tick_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_dvsr, cfg_cnt, start, stop,
        output cfg_ready, tick, q, tick_cnt, busy, done
    );

endinterface

// File: rtl/tick_sched_ctrl_prog_mod_counter.sv
// Runtime-modulus counter: counts 0..i_dvsr and wraps; clear beats enable.
module prog_mod_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_dvsr,
    output logic [W-1:0] o_q,
    output logic         o_max_tick
);

    logic [W-1:0] r_q;
    logic         w_at_max;

    assign w_at_max = (r_q == i_dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_at_max ? '0 : r_q + W'(1);
        end
    end

    assign o_q        = r_q;
    assign o_max_tick = w_at_max;

endmodule

// File: rtl/tick_sched_ctrl.sv
// Tick scheduler: IDLE/RUN sequencer around a programmable prescaler, with a
// shadowed config path so divisor/count changes land only on period boundaries.
module tick_sched_ctrl
    import tick_sched_pkg::*;
#(
    parameter int unsigned W  = TS_W_DEF,
    parameter int unsigned CW = TS_CW_DEF
) (
    input  logic        clk,
    input  logic        reset,
    tick_sched_if.slave bus
);

    localparam int unsigned CW1 = CW + 1;

    sched_state_t  r_state;
    logic [W-1:0]  r_dvsr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_shd_dvsr;
    logic [CW-1:0] r_shd_cnt;
    logic          r_pending;
    logic [CW-1:0] r_tick_cnt;

    logic          w_run;
    logic          w_start_idle;
    logic          w_restart;
    logic          w_cfg_ready;
    logic          w_cfg_fire;
    logic          w_max_tick;
    logic [W-1:0]  w_q;
    logic          w_tick;
    logic          w_done;
    logic          w_leave;
    logic          w_apply;

    always_comb begin
        w_run        = (r_state == RUN);
        w_start_idle = ~w_run & bus.start & ~bus.stop;
        w_restart    = w_run & bus.start & ~bus.stop;
        w_cfg_ready  = ~w_run | ~r_pending;
        w_cfg_fire   = bus.cfg_valid & w_cfg_ready;
        // A restart cycle swallows the tick even if q happens to sit at the divisor.
        w_tick       = w_run & w_max_tick & ~w_restart;
        w_done       = w_tick & (r_cnt != '0) &
                       (({1'b0, r_tick_cnt} + CW1'(1)) >= {1'b0, r_cnt});
        w_leave      = w_run & (bus.stop | w_done);
        w_apply      = r_pending & (w_tick | bus.stop | w_restart);
    end

    prog_mod_counter #(.W(W)) u_presc (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_start_idle | w_restart),
        .i_en       (w_run),
        .i_dvsr     (r_dvsr),
        .o_q        (w_q),
        .o_max_tick (w_max_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dvsr     <= '0;
            r_cnt      <= '0;
            r_shd_dvsr <= '0;
            r_shd_cnt  <= '0;
            r_pending  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            if (w_start_idle) begin
                r_state <= RUN;
            end else if (w_leave) begin
                r_state <= IDLE;
            end

            if (w_start_idle | w_restart) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + CW'(1);
            end

            // Idle writes go live at once; running writes wait in the shadow.
            if (w_cfg_fire & ~w_run) begin
                r_dvsr <= bus.cfg_dvsr;
                r_cnt  <= bus.cfg_cnt;
            end else if (w_apply) begin
                r_dvsr <= r_shd_dvsr;
                r_cnt  <= r_shd_cnt;
            end

            if (w_cfg_fire & w_run) begin
                r_shd_dvsr <= bus.cfg_dvsr;
                r_shd_cnt  <= bus.cfg_cnt;
                r_pending  <= 1'b1;
            end else if (w_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.tick      = w_tick;
    assign bus.done      = w_done;
    assign bus.busy      = w_run;
    assign bus.q         = w_q;
    assign bus.tick_cnt  = r_tick_cnt;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed bench for tick_sched_ctrl: vector table for plain runs, hand sequences for corners.
module tb_tick_sched_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc_no;

    tick_sched_if #(.W(16), .CW(8)) bus ();

    tick_sched_ctrl #(.W(16), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        st;
        logic        sp;
        logic        cv;
        logic [15:0] dv;
        logic [7:0]  cn;
        logic        e_tick;
        logic        e_done;
        logic        e_busy;
        logic        e_rdy;
        logic [15:0] e_q;
        logic [7:0]  e_tc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic st, input logic sp, input logic cv,
                       input logic [15:0] dv, input logic [7:0] cn,
                       input logic e_tick, input logic e_done, input logic e_busy,
                       input logic e_rdy, input logic [15:0] e_q, input logic [7:0] e_tc);
        vec_t v;
        v.st = st; v.sp = sp; v.cv = cv; v.dv = dv; v.cn = cn;
        v.e_tick = e_tick; v.e_done = e_done; v.e_busy = e_busy;
        v.e_rdy = e_rdy; v.e_q = e_q; v.e_tc = e_tc;
        vt.push_back(v);
    endtask

    // Drive one cycle's inputs just after the edge, then wait to mid-cycle for sampling.
    task automatic cyc(input logic rs, input logic st, input logic sp, input logic cv,
                       input logic [15:0] dv, input logic [7:0] cn);
        @(posedge clk);
        #1;
        reset         = rs;
        bus.start     = st;
        bus.stop      = sp;
        bus.cfg_valid = cv;
        bus.cfg_dvsr  = dv;
        bus.cfg_cnt   = cn;
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc_no, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_tick, input logic e_done,
                           input logic e_busy, input logic e_rdy,
                           input logic [15:0] e_q, input logic [7:0] e_tc);
        chk({tag, ".tick"},      32'(bus.tick),      32'(e_tick));
        chk({tag, ".done"},      32'(bus.done),      32'(e_done));
        chk({tag, ".busy"},      32'(bus.busy),      32'(e_busy));
        chk({tag, ".cfg_ready"}, 32'(bus.cfg_ready), 32'(e_rdy));
        chk({tag, ".q"},         32'(bus.q),         32'(e_q));
        chk({tag, ".tick_cnt"},  32'(bus.tick_cnt),  32'(e_tc));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc_no   = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_dvsr  = '0;
        bus.cfg_cnt   = '0;

        // Reset held two cycles.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_all("reset", 0, 0, 0, 1, 0, 0);

        // Continuous run, dvsr=3: ticks every 4th cycle, done never.
        add(0, 0, 1, 16'd3, 8'd0, 0, 0, 0, 1, 16'd0, 8'd0);
        add(1, 0, 0, 16'd0, 8'd0, 0, 0, 0, 1, 16'd0, 8'd0);
        for (int c = 1; c <= 17; c++)
            add(0, 0, 0, 16'd0, 8'd0, (c % 4) == 0, 0, 1, 1,
                16'((c - 1) % 4), 8'((c - 1) / 4));
        add(0, 1, 0, 16'd0, 8'd0, 0, 0, 1, 1, 16'd1, 8'd4);
        add(0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 1, 16'd2, 8'd4);
        // Burst of 3 ticks, dvsr=3: done only on the third tick.
        add(0, 0, 1, 16'd3, 8'd3, 0, 0, 0, 1, 16'd2, 8'd4);
        add(1, 0, 0, 16'd0, 8'd0, 0, 0, 0, 1, 16'd2, 8'd4);
        for (int c = 1; c <= 12; c++)
            add(0, 0, 0, 16'd0, 8'd0, (c % 4) == 0, c == 12, 1, 1,
                16'((c - 1) % 4), 8'((c - 1) / 4));
        add(0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 1, 16'd0, 8'd3);
        add(0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 1, 16'd0, 8'd3);

        foreach (vt[i]) begin
            cyc(0, vt[i].st, vt[i].sp, vt[i].cv, vt[i].dv, vt[i].cn);
            chk_all($sformatf("vec%0d", i), vt[i].e_tick, vt[i].e_done, vt[i].e_busy,
                    vt[i].e_rdy, vt[i].e_q, vt[i].e_tc);
        end

        // Divisor change mid-run: takes effect only after the next tick.
        cyc(0, 0, 0, 1, 16'd3, 8'd0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 16'd1, 8'd0);
        chk("upd.c6.ready", 32'(bus.cfg_ready), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("upd.c7.ready", 32'(bus.cfg_ready), 32'd0);
        chk("upd.c7.tick",  32'(bus.tick),      32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("upd.c8.ready", 32'(bus.cfg_ready), 32'd0);
        chk("upd.c8.tick",  32'(bus.tick),      32'd1);
        for (int c = 9; c <= 14; c++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk($sformatf("upd.c%0d.ready", c), 32'(bus.cfg_ready), 32'd1);
            chk($sformatf("upd.c%0d.tick", c),  32'(bus.tick), 32'((c % 2) == 0));
        end
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // start & stop together: ignored in IDLE, stops a run.
        cyc(0, 1, 1, 0, 0, 0);
        chk("ss.idle.busy", 32'(bus.busy), 32'd0);
        cyc(0, 0, 0, 1, 16'd3, 8'd0);
        chk("ss.idle.busy_next", 32'(bus.busy), 32'd0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ss.run.c1.busy", 32'(bus.busy), 32'd1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("ss.run.c2.tick", 32'(bus.tick), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ss.run.c3.busy", 32'(bus.busy), 32'd0);
        chk("ss.run.c3.tick", 32'(bus.tick), 32'd0);

        // Reset during RUN with a config pending: all cleared, pending dropped.
        cyc(0, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 16'd1, 8'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst.pend.ready", 32'(bus.cfg_ready), 32'd0);
        chk("rst.pend.tick_cnt", 32'(bus.tick_cnt), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("rst.mid", 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst.dvsr0.c1.tick", 32'(bus.tick), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst.dvsr0.c2.tick", 32'(bus.tick), 32'd1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // dvsr=0, burst of 5.
        cyc(0, 0, 0, 1, 16'd0, 8'd5);
        cyc(0, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk_all($sformatf("b5.c%0d", c), 1, c == 5, 1, 1, 16'd0, 8'(c - 1));
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("b5.c6", 0, 0, 0, 1, 16'd0, 8'd5);

        // Same burst restarted at c3: count starts over, done after 5 fresh ticks.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rs.c1.tick", 32'(bus.tick), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rs.c2.tick_cnt", 32'(bus.tick_cnt), 32'd1);
        cyc(0, 1, 0, 0, 0, 0);
        chk_all("rs.c3", 0, 0, 1, 1, 16'd0, 8'd2);
        for (int c = 4; c <= 8; c++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk_all($sformatf("rs.c%0d", c), 1, c == 8, 1, 1, 16'd0, 8'(c - 4));
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk_all("rs.c9", 0, 0, 0, 1, 16'd0, 8'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
